// File: rtl/uart_tx_framer.sv
// UART transmit framer: a small byte FIFO feeding a frame shifter that advances one bit per tick.
// Optional even-parity bit between data and stop, compiled in with `define UART_TX_PARITY_EN.
module uart_tx_framer #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 full,
   output logic                 busy,
   output logic                 done,
   output logic                 tx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP  = 3'd3
   } state_t;

`ifdef UART_TX_PARITY_EN
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      even_parity = ^d;
   endfunction
`endif

   logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]        count_r;
   logic                 push_s, pop_s, empty_s;
   logic [DATA_BITS-1:0] head_s;

   state_t               state_r, state_n_s;
   logic [DATA_BITS-1:0] shift_r, shift_n_s;
   logic [BW-1:0]        cnt_r, cnt_n_s;
   logic                 tx_r, tx_n_s;
   logic                 done_r, done_n_s;
`ifdef UART_TX_PARITY_EN
   logic                 par_r, par_n_s;
`endif

   assign empty_s = (count_r == {CW{1'b0}});
   assign full    = (count_r == FULL_CNT);
   assign busy    = (state_r != IDLE) | ~empty_s;
   assign push_s  = wr_en & ~full;
   assign head_s  = mem_r[rd_ptr_r];
   assign tx      = tx_r;
   assign done    = done_r;

   // FIFO storage and pointers; a same-cycle write to an empty FIFO is never popped on that edge
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Frame sequencing: every transition, and every change of tx, waits for a tick
   always_comb begin
      state_n_s = state_r;
      shift_n_s = shift_r;
      cnt_n_s   = cnt_r;
      tx_n_s    = tx_r;
      done_n_s  = 1'b0;
      pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n_s   = par_r;
`endif
      if (tick) begin
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  pop_s = 1'b1;
               end else begin
                  tx_n_s = 1'b1;
               end
            end
            START: begin
               tx_n_s    = shift_r[0];
               shift_n_s = {1'b0, shift_r[DATA_BITS-1:1]};
               cnt_n_s   = {BW{1'b0}};
               state_n_s = DATA;
            end
            DATA: begin
               if (cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  tx_n_s    = par_r;
                  state_n_s = PARITY;
`else
                  tx_n_s    = 1'b1;
                  state_n_s = STOP;
`endif
               end else begin
                  tx_n_s    = shift_r[0];
                  shift_n_s = {1'b0, shift_r[DATA_BITS-1:1]};
                  cnt_n_s   = cnt_r + BIT_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               tx_n_s    = 1'b1;
               state_n_s = STOP;
            end
`endif
            STOP: begin
               done_n_s = 1'b1;
               if (!empty_s) begin
                  pop_s = 1'b1;
               end else begin
                  tx_n_s    = 1'b1;
                  state_n_s = IDLE;
               end
            end
            default: begin
               tx_n_s    = 1'b1;
               state_n_s = IDLE;
            end
         endcase
      end else begin
         state_n_s = state_r;
      end
      if (pop_s) begin
         shift_n_s = head_s;
         tx_n_s    = 1'b0;
         state_n_s = START;
`ifdef UART_TX_PARITY_EN
         par_n_s   = even_parity(head_s);
`endif
      end else begin
         shift_n_s = shift_n_s;
      end
   end

   // Frame registers; reset aborts any frame in flight and returns the line to idle-high
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         shift_r <= {DATA_BITS{1'b0}};
         cnt_r   <= {BW{1'b0}};
         tx_r    <= 1'b1;
         done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_n_s;
         shift_r <= shift_n_s;
         cnt_r   <= cnt_n_s;
         tx_r    <= tx_n_s;
         done_r  <= done_n_s;
`ifdef UART_TX_PARITY_EN
         par_r   <= par_n_s;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: a byte scoreboard filled on accepted writes is drained
// by a line monitor that decodes each frame tick by tick.
module tb_uart_tx_framer;
   localparam int DB    = 8;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int STOP_IDX = DB + 1 + PAR;

   logic          clk, reset, tick, wr_en;
   logic [DB-1:0] wr_data;
   logic          full, busy, done, tx;

   uart_tx_framer #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .busy(busy), .done(done), .tx(tx)
   );

   int            compared = 0;
   int            mismatched = 0;
   logic [DB-1:0] exp_q[$];
   logic [DB-1:0] cur;
   bit            in_frame = 1'b0;
   int            idx = 0;
   int            frames = 0;
   int            dones = 0;
   int            tdiv = 0;
   bit            tick_on = 1'b1;
   logic          prev_tx = 1'b1;
   int            f0, d0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Line monitor, called #1 after every edge; t is the tick that edge saw
   task automatic mon(input logic t);
      logic exp_done;
      exp_done = (t && in_frame && idx == STOP_IDX) ? 1'b1 : 1'b0;
      chk("done", done, exp_done);
      if (done === 1'b1) dones++;
      if (t !== 1'b1) begin
         chk("tx_hold", tx, prev_tx);
      end else if (!in_frame) begin
         if (tx === 1'b0) begin
            chk("start_expected", (exp_q.size() != 0) ? 1'b1 : 1'b0, 1'b1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               in_frame = 1'b1;
               idx = 0;
            end
         end
      end else begin
         idx++;
         if (idx <= DB) chk("data_bit", tx, cur[idx-1]);
         else if (idx < STOP_IDX) chk("parity_bit", tx, ^cur);
         else if (idx == STOP_IDX) chk("stop_bit", tx, 1'b1);
         else begin
            frames++;
            if (exp_q.size() != 0) begin
               chk("b2b_start", tx, 1'b0);
               cur = exp_q.pop_front();
               idx = 0;
            end else begin
               chk("idle_after_stop", tx, 1'b1);
               in_frame = 1'b0;
            end
         end
      end
      prev_tx = tx;
   endtask

   task automatic cyc();
      tick = (tick_on && tdiv == 3) ? 1'b1 : 1'b0;
      tdiv = (tdiv + 1) % 4;
      @(posedge clk);
      #1;
      mon(tick);
      wr_en = 1'b0;
   endtask

   task automatic wr(input logic [DB-1:0] b, input bit accept);
      wr_en = 1'b1;
      wr_data = b;
      if (accept) exp_q.push_back(b);
      cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      tick = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      in_frame = 1'b0;
      idx = 0;
      prev_tx = tx;
   endtask

   task automatic wait_idx(input int n);
      int k = 0;
      while (!(in_frame && idx == n) && k < 200) begin
         cyc();
         k++;
      end
      chk("reached_bit", (in_frame && idx == n) ? 1'b1 : 1'b0, 1'b1);
   endtask

   task automatic drain();
      int k = 0;
      while (!(!in_frame && exp_q.size() == 0 && busy === 1'b0) && k < 600) begin
         cyc();
         k++;
      end
      chk("drain_timeout", (k < 600) ? 1'b1 : 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_data = '0;
      do_reset();
      do_reset();
      chk("rst_tx", tx, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_full", full, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // single 0xA5 frame
      f0 = frames; d0 = dones;
      wr(8'hA5, 1'b1);
      chk("busy_after_write", busy, 1'b1);
      wait_idx(5);
      chk("busy_mid_frame", busy, 1'b1);
      drain();
      chk_int("a5_frames", frames - f0, 1);
      chk_int("a5_dones", dones - d0, 1);
      chk("a5_busy_end", busy, 1'b0);

      // three back-to-back frames
      f0 = frames; d0 = dones;
      wr(8'h00, 1'b1);
      wr(8'hFF, 1'b1);
      wr(8'h3C, 1'b1);
      drain();
      chk_int("b2b_frames", frames - f0, 3);
      chk_int("b2b_dones", dones - d0, 3);

      // overfill with tick held low
      f0 = frames;
      tick_on = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr(8'h10 + 8'(i), (i < DEPTH));
         chk("full_flag", full, (i >= DEPTH - 1) ? 1'b1 : 1'b0);
      end
      chk_int("no_frames_while_tick_low", frames - f0, 0);
      tick_on = 1'b1;
      drain();
      chk_int("overfill_frames", frames - f0, DEPTH);
      chk("overfill_full_end", full, 1'b0);

      // reset during third data bit with two bytes queued
      f0 = frames;
      wr(8'h55, 1'b1);
      wr(8'h11, 1'b1);
      wr(8'h22, 1'b1);
      wait_idx(3);
      do_reset();
      chk("abort_tx", tx, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_full", full, 1'b0);
      chk("abort_done", done, 1'b0);
      repeat (60) cyc();
      chk_int("abort_no_frames", frames - f0, 0);
      chk("abort_idle_tx", tx, 1'b1);

      // write coinciding with tick while idle
      while (tdiv != 3) cyc();
      wr(8'h81, 1'b1);
      chk("no_start_on_write_tick", tx, 1'b1);
      chk("busy_queued", busy, 1'b1);
      repeat (3) cyc();
      chk("still_idle_before_tick", tx, 1'b1);
      cyc();
      chk("start_next_tick", tx, 1'b0);
      drain();

      // 0x07: parity bit is 1 when parity is compiled in
      f0 = frames;
      wr(8'h07, 1'b1);
      drain();
      chk_int("x07_frames", frames - f0, 1);
      chk_int("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit stage driven by the baud-rate tick generator: it accepts bytes from game logic into a small FIFO and shifts them out on `tx` as 8N1 UART frames, advancing exactly one bit per `tick` pulse. It sits directly downstream of the tick generator, whose single-cycle `tick` it consumes, and directly upstream of the board TX pin.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5..8, sent LSB first
- `FIFO_DEPTH`, 4, byte FIFO entries, power of two, ≥2
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high; clock `clk`
- `tick` in 1: one-`clk` pulse per bit period, from the tick generator
- `wr_en` in 1: write strobe; `wr_data` is pushed when `wr_en` is high and `full` is low
- `wr_data` in DATA_BITS: byte to transmit
- `full` out 1: FIFO holds FIFO_DEPTH entries
- `busy` out 1: state ≠ IDLE or FIFO non-empty
- `done` out 1: one-cycle pulse per completed frame
- `tx` out 1: serial line, idle high

## Operation
- FIFO: circular buffer; `wr_ptr`/`rd_ptr` are log2(FIFO_DEPTH) bits and wrap modulo depth; `count` is log2(FIFO_DEPTH)+1 bits. A write while `full` is dropped; state is unchanged.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. All transitions happen only in cycles with `tick`=1; with `tick`=0 every register except the FIFO holds.
- IDLE: `tx`=1. On `tick` with FIFO non-empty, pop the head into the shift register, drive `tx`=0, and go to START.
- START: on `tick`, drive `tx`=shift[0], shift right, bit counter=0, and go to DATA.
- DATA: on `tick`, if bit counter = DATA_BITS-1, go to STOP (or PARITY) with `tx`=1 (or parity); else drive the next bit and increment the counter.
- STOP: on `tick`, the frame completes and `done` is set. If the FIFO is non-empty, pop, drive `tx`=0, and go to START (back-to-back frames, no idle bit). Otherwise drive `tx`=1 and go to IDLE.
- Each bit occupies exactly one tick-to-tick interval. A frame lasts DATA_BITS+2 tick intervals (+1 with parity).

## Timing
- Reset values: `tx`=1, `done`=0, `full`=0, `busy`=0; FIFO empty; state IDLE.
- Reset mid-frame aborts the frame: `tx`=1 after the reset edge, and FIFO contents are discarded.
- `tx` is registered and changes only on the clock edge at which `tick`=1.
- `done` is registered and high for the single cycle after the tick edge that ends the stop bit.
- `full` and `busy` are combinational from registered state.
- Write to an empty FIFO in the same cycle as `tick` while in IDLE: the byte is not popped on that edge. The start bit begins on the next `tick`. Worst-case latency from write to start bit is one tick period plus one `clk`.
- Frame start is always tick-aligned. No partial first bit.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is compiled in. After the last data bit, `tx` = XOR of the data bits (even parity) for one tick interval, then STOP. Frame length is DATA_BITS+3 ticks.
- Not defined: no PARITY state. DATA goes directly to STOP, giving 8N1 framing.

## Test plan
- Tick every 4 clocks, write 0xA5 once → `tx` per tick interval: 0,1,0,1,0,0,1,0,1,1. `done` pulses once. `busy` falls after STOP.
- Write 0x00, 0xFF, 0x3C in consecutive cycles → three frames back-to-back with no idle bit between stop and start, and three `done` pulses.
- With FIFO_DEPTH=4 and `tick` held low, write 6 bytes → `full` asserts after the 4th write. Bytes 5 and 6 are dropped. Enable `tick` → exactly 4 frames are sent.
- Assert `reset` during the 3rd data bit of 0x55 with 2 bytes queued → `tx`=1 the next cycle, FIFO empty, `busy`=0, no further frames.
- Write 0x81 in the same cycle as `tick` → no start bit on that edge; start bit begins on the following tick.
- With `UART_TX_PARITY_EN`, send 0x07 → data 1,1,1,0,0,0,0,0, parity bit 1, stop 1, for a frame of 11 ticks.
